// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter in front of a fixed-latency bitwise logic unit.
// A granted request is executed for LAT cycles and its result held until acknowledged.
module logic_unit_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [1:0]  op0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [1:0]  op1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt1,
  output logic        res_valid,
  output logic        res_id,
  output logic [31:0] res_data,
  input  logic        res_ack
);

  if (LAT < 1 || LAT > 15) begin : g_lat_check
    $error("logic_unit_arbiter: LAT must be in 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state, state_next;
  logic        ptr;
  logic [3:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        id_q;
  logic        grant;
  logic [31:0] alu;

  // ptr holds the last requester served; a tie goes to the other one.
  // Grants are also gated by reset_n so nothing is granted while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n && state == IDLE) begin
      if (req0 && (!req1 || ptr)) gnt0 = 1'b1;
      else if (req1)              gnt1 = 1'b1;
    end
  end

  assign grant = gnt0 | gnt1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = EXEC;
      EXEC:    if (cnt == '0) state_next = DONE;
      DONE:    if (res_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu = '0;
    case (op_q)
      2'b00: alu = ~a_q;
      2'b01: alu = a_q & b_q;
      2'b10: alu = a_q | b_q;
      2'b11: alu = a_q ^ b_q;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= 1'b1;
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            op_q <= gnt1 ? op1 : op0;
            a_q  <= gnt1 ? a1  : a0;
            b_q  <= gnt1 ? b1  : b0;
            id_q <= gnt1;
            cnt  <= CNT_LOAD;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            res_valid <= 1'b1;
            res_data  <= alu;
            res_id    <= id_q;
          end
        end
        DONE: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            ptr       <= res_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: vector table on a LAT=2 instance,
// plus round-robin, reset-abort and LAT=1 sequences, with a result scoreboard.
module tb_logic_unit_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0, req1, res_ack;
  logic [1:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;

  logic        gnt0, gnt1, res_valid, res_id;
  logic [31:0] res_data;
  logic        gnt0_l1, gnt1_l1, res_valid_l1, res_id_l1;
  logic [31:0] res_data_l1;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  logic_unit_arbiter #(.LAT(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .res_ack(res_ack)
  );

  logic_unit_arbiter #(.LAT(1)) dut_l1 (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0_l1),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1_l1),
    .res_valid(res_valid_l1), .res_id(res_id_l1), .res_data(res_data_l1),
    .res_ack(res_ack)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic id, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    if (!id) begin
      req0 = 1'b1; op0 = op; a0 = a; b0 = b;
    end else begin
      req1 = 1'b1; op1 = op; a1 = a; b1 = b;
    end
  endtask

  task automatic pop_compare(input string name, input logic id, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, "_id"}, {31'd0, id}, {31'd0, e.id});
      check({name, "_data"}, data, e.data);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; res_ack = 1'b0;
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One single-requester transaction on the LAT=2 instance.
  task automatic run_vec(input vec_t v);
    int cycles;
    @(negedge clock);
    drive_req(v.id, v.op, v.a, v.b);
    #1;
    check("vec_grant", {30'd0, gnt1, gnt0}, v.id ? 32'd2 : 32'd1);
    sb.push_back('{v.id, v.exp});
    @(posedge clock); #1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1; op0 = ~op0; op1 = ~op1;
    res_ack = 1'b1;
    check("vec_exec_nogrant", {30'd0, gnt1, gnt0}, 32'd0);
    cycles = 0;
    while (!res_valid && cycles < 20) begin
      @(posedge clock); #1;
      cycles++;
      if (cycles == 1) res_ack = 1'b0;
    end
    res_ack = 1'b0;
    check("vec_latency", cycles, 32'd2);
    pop_compare("vec_result", res_id, res_data);
    repeat (3) begin
      @(negedge clock);
      check("vec_hold_valid", {31'd0, res_valid}, 32'd1);
      check("vec_hold_data", res_data, v.exp);
    end
    @(negedge clock);
    res_ack = 1'b1;
    @(posedge clock); #1;
    check("vec_clear", {31'd0, res_valid}, 32'd0);
    res_ack = 1'b0;
  endtask

  initial begin
    int ngr;
    int nres;
    logic exp_order[3];

    vecs[0] = '{1'b0, 2'b00, 32'h0000FFFF, 32'h12345678, 32'hFFFF0000};
    vecs[1] = '{1'b1, 2'b01, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[2] = '{1'b0, 2'b10, 32'h0000000F, 32'h000000F0, 32'h000000FF};
    vecs[3] = '{1'b1, 2'b11, 32'h12345678, 32'h12345678, 32'h00000000};
    vecs[4] = '{1'b0, 2'b11, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555};
    vecs[5] = '{1'b1, 2'b00, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[6] = '{1'b0, 2'b01, 32'hFFFFFFFF, 32'h80000001, 32'h80000001};
    vecs[7] = '{1'b1, 2'b10, 32'h80000000, 32'h00000001, 32'h80000001};
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;

    tests_run = 0;
    tests_failed = 0;
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; res_ack = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset with a request pending: no grant, outputs cleared.
    @(negedge clock);
    reset_n = 1'b0;
    req0 = 1'b1;
    #1;
    check("rst_gnt0", {31'd0, gnt0}, 32'd0);
    check("rst_gnt0_l1", {31'd0, gnt0_l1}, 32'd0);
    check("rst_valid", {31'd0, res_valid}, 32'd0);
    check("rst_id", {31'd0, res_id}, 32'd0);
    check("rst_data", res_data, 32'd0);
    req0 = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Round robin with both requests held and res_ack held high.
    @(negedge clock);
    drive_req(1'b0, 2'b01, 32'hF0F0F0F0, 32'hFF00FF00);
    drive_req(1'b1, 2'b01, 32'hF0F0F0F0, 32'hFF00FF00);
    res_ack = 1'b1;
    ngr = 0;
    nres = 0;
    for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
      #1;
      if (gnt0 && gnt1) check("rr_both_granted", 32'd1, 32'd0);
      if ((gnt0 || gnt1) && ngr < 3) begin
        check("rr_order", {31'd0, gnt1}, {31'd0, exp_order[ngr]});
        sb.push_back('{exp_order[ngr], 32'hF000F000});
        ngr++;
      end
      if (res_valid) begin
        check("rr_done_nogrant", {30'd0, gnt1, gnt0}, 32'd0);
        pop_compare("rr_result", res_id, res_data);
        nres++;
      end
      @(negedge clock);
    end
    check("rr_grants", ngr, 32'd3);
    check("rr_results", nres, 32'd3);
    req0 = 1'b0; req1 = 1'b0; res_ack = 1'b0;
    do_reset();

    // Serve requester 0 so the pointer favours 1, then abort a requester-1 op.
    run_vec(vecs[2]);
    @(negedge clock);
    drive_req(1'b1, 2'b11, 32'hDEADBEEF, 32'h0F0F0F0F);
    #1;
    check("abort_grant", {31'd0, gnt1}, 32'd1);
    @(posedge clock); #1;
    req1 = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_valid_in_reset", {31'd0, res_valid}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("abort_no_result", {31'd0, res_valid}, 32'd0);
    end
    drive_req(1'b0, 2'b00, 32'h0, 32'h0);
    drive_req(1'b1, 2'b00, 32'h0, 32'h0);
    #1;
    check("abort_tie_grant", {30'd0, gnt1, gnt0}, 32'd1);
    do_reset();

    // LAT=1 instance; res_ack pulsed during the single EXEC cycle.
    @(negedge clock);
    drive_req(1'b0, 2'b10, 32'h0000000F, 32'h000000F0);
    #1;
    check("l1_grant", {30'd0, gnt1_l1, gnt0_l1}, 32'd1);
    sb.push_back('{1'b0, 32'h000000FF});
    @(posedge clock); #1;
    req0 = 1'b0; a0 = 32'hFFFFFFFF; b0 = 32'hFFFFFFFF;
    res_ack = 1'b1;
    check("l1_exec_valid", {31'd0, res_valid_l1}, 32'd0);
    @(posedge clock); #1;
    check("l1_valid", {31'd0, res_valid_l1}, 32'd1);
    pop_compare("l1_result", res_id_l1, res_data_l1);
    res_ack = 1'b0;
    @(posedge clock); #1;
    check("l1_hold_valid", {31'd0, res_valid_l1}, 32'd1);
    res_ack = 1'b1;
    @(posedge clock); #1;
    check("l1_clear", {31'd0, res_valid_l1}, 32'd0);
    res_ack = 1'b0;

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
